rvb_crc: RTL
============

Name: rvb_crc

Overview:
- Iterative CRC32 / CRC32C execution unit for the bitmanip extension, implementing crc32.[bhwd] and crc32c.[bhwd].
- It is the responder side of the din/dout valid/ready interface: it accepts operands on din, computes over several cycles, and returns rd on dout.
- It drops into the same benches and core pipelines as the other rvb_* units, and uses the same handshake and operand port names.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- BPC, 8, CRC bits processed per busy cycle; one of 1, 2, 4, 8.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- din_valid  input  1  operand valid.
- din_ready  output  1  unit can accept an operand this cycle.
- din_rs1  input  XLEN  CRC state/data operand.
- din_insn20  input  1  size bit 0 (insn[20]).
- din_insn21  input  1  size bit 1 (insn[21]).
- din_insn23  input  1  1 = Castagnoli (crc32c), 0 = crc32.
- dout_valid  output  1  result valid.
- dout_ready  input  1  consumer accepts result.
- dout_rd  output  XLEN  result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, dout_valid=0, dout_rd=0, step counter=0.
  - din_ready is forced 0 while reset=0.
  - An in-flight operation is discarded and no result is produced for it.
- Size decode from {insn21,insn20}:
  - 00 = b (8 bits), 01 = h (16), 10 = w (32), 11 = d (64).
  - With XLEN=32, size 11 executes as w.
- Polynomial (reflected):
  - insn23=0: P = 0xEDB88320.
  - insn23=1: P = 0x82F63B78.
  - Zero-extended to XLEN.
- Algorithm: x = rs1, then for nbits iterations: x = (x >> 1) ^ (P & {XLEN{x[0]}}). Logical shift, zero fill from the top. rd = x.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - din_ready=1.
  - On din_valid && din_ready: x <= rs1; latch P; cnt <= nbits/BPC; go to BUSY.
- BUSY:
  - din_ready=0, dout_valid=0.
  - Each cycle applies BPC iterations (unrolled) and decrements cnt.
  - The cycle with cnt==1 loads the final x into dout_rd and moves to DONE.
- DONE:
  - dout_valid=1; dout_rd holds stable while dout_ready=0.
  - On dout_ready: if din_valid, accept a new operand in the same cycle (din_ready = dout_ready in DONE) and go to BUSY; otherwise go to IDLE.
- Latency: dout_valid rises exactly nbits/BPC cycles after the accepting edge.
  - Default BPC=8: b=1, h=2, w=4, d=8 cycles.
  - Throughput with back-to-back operands: one op per nbits/BPC + 1 cycles.
- No combinational path from din_valid to din_ready, or from dout_ready to dout_valid.
  - din_ready depends only on state, dout_ready and reset.
- din_rs1 and insn bits are sampled only on the accepting edge; changes at other times are ignored.
- dout_rd is not cleared on handshake; it keeps the last result until overwritten.
- Result ordering is strictly FIFO. Only one operation is in flight at a time.

Test Plan:
- crc32.b, rs1=0x00000001 -> rd=0x77073096, dout_valid 1 cycle after accept (BPC=8).
- crc32.b, rs1=0x00000080 -> 0xEDB88320. crc32c.b, rs1=0x00000080 -> 0x82F63B78. crc32c.b, rs1=0x00000001 -> 0xF26B8303.
- crc32.b, rs1=0x00000100 -> 0x00000001 (upper bits shift through). crc32.w, rs1=0 -> 0. With XLEN=32, crc32.d of rs1=0x00000001 equals crc32.w of the same operand.
- Backpressure: hold dout_ready=0 for 5 cycles in DONE -> dout_valid stays 1, dout_rd unchanged, din_ready=0. Then dout_ready=1 with din_valid=1 -> new op accepted on that same edge.
- Reset mid-BUSY during crc32.w: dout_valid=0 and dout_rd=0 immediately (asynchronous, no clock edge). After release, the next op completes correctly and no stale result appears.
- Randomized din_valid/dout_ready against a software model, 1000 ops over all sizes and polys, for BPC in {1,8} and XLEN in {32,64} -> all results match, in order.

Source files
------------

// File: rtl/rvb_crc.sv
// rtl/rvb_crc.sv - iterative CRC32/CRC32C unit (crc32.[bhwd], crc32c.[bhwd])
// Processes BPC reflected-CRC bits per busy cycle behind a din/dout valid/ready handshake.
module rvb_crc #(
  parameter int XLEN = 32,
  parameter int BPC  = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [XLEN-1:0] din_rs1,
  input  logic            din_insn20,
  input  logic            din_insn21,
  input  logic            din_insn23,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_rd
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int SH = (BPC == 1) ? 0 : (BPC == 2) ? 1 : (BPC == 4) ? 2 : 3;
  localparam logic [XLEN-1:0] POLY_CRC32  = XLEN'(32'hEDB88320);
  localparam logic [XLEN-1:0] POLY_CRC32C = XLEN'(32'h82F63B78);

  state_t          state_q, state_d;
  logic [XLEN-1:0] x_q, x_d;
  logic [XLEN-1:0] poly_q, poly_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [6:0]      nbits;
  logic [XLEN-1:0] x_step;
  logic            accept;

  function automatic logic [XLEN-1:0] crc_bits(input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] p);
    logic [XLEN-1:0] v;
    v = x;
    for (int i = 0; i < BPC; i++) begin
      v = (v >> 1) ^ (p & {XLEN{v[0]}});
    end
    return v;
  endfunction

  // Doubleword collapses to word on a 32-bit datapath.
  always_comb begin
    case ({din_insn21, din_insn20})
      2'b00:   nbits = 7'd8;
      2'b01:   nbits = 7'd16;
      2'b10:   nbits = 7'd32;
      default: nbits = (XLEN == 64) ? 7'd64 : 7'd32;
    endcase
  end

  assign x_step  = crc_bits(x_q, poly_q);
  assign accept  = din_valid & din_ready;
  assign dout_rd = rd_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      poly_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      poly_q  <= poly_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    poly_d  = poly_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        x_d   = x_step;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          rd_d    = x_step;
          state_d = DONE;
        end
      end
      DONE: if (dout_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    // Accept only happens in IDLE or DONE, so it never collides with the BUSY update.
    if (accept) begin
      x_d    = din_rs1;
      poly_d = din_insn23 ? POLY_CRC32C : POLY_CRC32;
      cnt_d  = nbits >> SH;
    end
  end

  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    case (state_q)
      IDLE: din_ready = reset;
      DONE: begin
        din_ready  = reset & dout_ready;
        dout_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
